// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer: FSM state encoding
// and button indices.
package stopwatch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int NUM_BTNS  = 4;
    localparam int BTN_START = 0;
    localparam int BTN_LAP   = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_CLEAR = 3;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and datapath control outputs of the stopwatch sequencer.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               btn_start;
    logic               btn_lap;
    logic               btn_stop;
    logic               btn_clear;
    logic               tick_en;
    logic               clear;
    logic               lap_capture;
    logic               show_lap;
    logic               running;
    logic [STATE_W-1:0] state;

    modport slave (
        input  btn_start, btn_lap, btn_stop, btn_clear,
        output tick_en, clear, lap_capture, show_lap, running, state
    );

    modport master (
        output btn_start, btn_lap, btn_stop, btn_clear,
        input  tick_en, clear, lap_capture, show_lap, running, state
    );
endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One button channel: 2-flop synchroniser, mismatch-run debounce counter and
// a registered one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn_raw,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            press_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= btn_raw;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            press_reg   <= level_reg & ~level_d_reg;
            // The level flips on the edge after the mismatch count hits the limit.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign press = press_reg;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced buttons drive an IDLE/RUN/PAUSE FSM,
// a 100 Hz timebase and the lap-hold countdown feeding the display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV         = 120000,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int LAP_HOLD_TICKS  = 200
) (
    input  logic             CLK,
    input  logic             RST,
    stopwatch_ctrl_if.slave  sw
);
    localparam int         TB_W       = $clog2(CLK_DIV);
    localparam logic [7:0] LAP_HOLD_8 = 8'(LAP_HOLD_TICKS);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_press;

    assign btn_raw[BTN_START] = sw.btn_start;
    assign btn_raw[BTN_LAP]   = sw.btn_lap;
    assign btn_raw[BTN_STOP]  = sw.btn_stop;
    assign btn_raw[BTN_CLEAR] = sw.btn_clear;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .CLK    (CLK),
                .RST    (RST),
                .btn_raw(btn_raw[gi]),
                .press  (btn_press[gi])
            );
        end
    endgenerate

    logic [TB_W-1:0] tb_cnt_reg;
    logic            tick_base;
    state_t          state_reg, state_next;
    logic [7:0]      lap_timer_reg, lap_timer_next;
    logic            tick_en_reg, tick_en_next;
    logic            clear_reg, clear_next;
    logic            lap_cap_reg, lap_cap_next;
    logic            show_lap_reg;
    logic            running_reg;

    assign tick_base = (tb_cnt_reg == TB_W'(CLK_DIV - 1));

    always_comb begin
        state_next     = state_reg;
        clear_next     = 1'b0;
        lap_cap_next   = 1'b0;
        tick_en_next   = tick_base && (state_reg == ST_RUN) && !btn_press[BTN_CLEAR];
        lap_timer_next = (tick_base && lap_timer_reg != 8'd0) ? lap_timer_reg - 8'd1
                                                              : lap_timer_reg;
        // Only the highest-priority event present is acted on; the rest are dropped.
        if (btn_press[BTN_CLEAR]) begin
            state_next     = ST_IDLE;
            clear_next     = 1'b1;
            lap_timer_next = 8'd0;
        end else if (btn_press[BTN_STOP]) begin
            if (state_reg == ST_RUN) state_next = ST_PAUSE;
        end else if (btn_press[BTN_START]) begin
            if (state_reg != ST_RUN) state_next = ST_RUN;
        end else if (btn_press[BTN_LAP] && state_reg != ST_IDLE) begin
            lap_cap_next   = 1'b1;
            lap_timer_next = LAP_HOLD_8;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tb_cnt_reg    <= '0;
            state_reg     <= ST_IDLE;
            lap_timer_reg <= 8'd0;
            tick_en_reg   <= 1'b0;
            clear_reg     <= 1'b0;
            lap_cap_reg   <= 1'b0;
            show_lap_reg  <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            tb_cnt_reg    <= tick_base ? '0 : tb_cnt_reg + 1'b1;
            state_reg     <= state_next;
            lap_timer_reg <= lap_timer_next;
            tick_en_reg   <= tick_en_next;
            clear_reg     <= clear_next;
            lap_cap_reg   <= lap_cap_next;
            show_lap_reg  <= (lap_timer_reg != 8'd0);
            running_reg   <= (state_next == ST_RUN);
        end
    end

    assign sw.tick_en     = tick_en_reg;
    assign sw.clear       = clear_reg;
    assign sw.lap_capture = lap_cap_reg;
    assign sw.show_lap    = show_lap_reg;
    assign sw.running     = running_reg;
    assign sw.state       = state_reg;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and randomized checks of stopwatch_ctrl against a cycle-level
// behavioural model built from the button, timebase, FSM and lap-hold rules.
module tb_stopwatch_ctrl;
    localparam int CLK_DIV = 10;
    localparam int DEB     = 4;
    localparam int HOLD    = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    stopwatch_ctrl_if sw_if();

    stopwatch_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .LAP_HOLD_TICKS (HOLD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .sw (sw_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // reference model state
    bit [3:0] m_r1, m_r2, m_lvl, m_press;
    int       m_streak [4];
    int       m_rise   [4];
    int       m_tb, m_lap, m_st;
    bit       m_tick_en, m_clear, m_lapcap, m_show, m_run;

    // observation counters for directed checks
    int cnt_tick, cnt_clear, cnt_lapcap, show_len;
    int last_tick, tick_gap_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit       tb_tick;
        bit [3:0] ev;
        bit [3:0] raw;
        bit       loaded;
        bit       s2;
        raw = {sw_if.btn_clear, sw_if.btn_stop, sw_if.btn_lap, sw_if.btn_start};
        if (RST) begin
            m_r1 = '0; m_r2 = '0; m_lvl = '0; m_press = '0;
            for (int b = 0; b < 4; b++) begin m_streak[b] = 0; m_rise[b] = -100; end
            m_tb = 0; m_lap = 0; m_st = 0;
            m_tick_en = 0; m_clear = 0; m_lapcap = 0; m_show = 0; m_run = 0;
        end else begin
            tb_tick   = (m_tb == CLK_DIV - 1);
            ev        = m_press;
            loaded    = 0;
            m_show    = (m_lap != 0);
            m_tick_en = tb_tick && (m_st == 1) && !ev[3];
            m_clear   = ev[3];
            m_lapcap  = 0;
            if (ev[3]) begin
                m_st = 0; m_lap = 0; loaded = 1;
            end else if (ev[2]) begin
                if (m_st == 1) m_st = 2;
            end else if (ev[0]) begin
                m_st = 1;
            end else if (ev[1] && m_st != 0) begin
                m_lapcap = 1; m_lap = HOLD; loaded = 1;
            end
            if (!loaded && tb_tick && m_lap > 0) m_lap--;
            m_run = (m_st == 1);
            m_tb  = (m_tb + 1) % CLK_DIV;
            // press appears the edge after the debounced level rose
            for (int b = 0; b < 4; b++) begin
                m_press[b] = (m_rise[b] == edge_n - 1);
                s2 = m_r2[b];
                if (s2 != m_lvl[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DEB + 1) begin
                        m_lvl[b]    = s2;
                        m_streak[b] = 0;
                        if (s2) m_rise[b] = edge_n;
                    end
                end else begin
                    m_streak[b] = 0;
                end
            end
            m_r2 = m_r1;
            m_r1 = raw;
        end
        edge_n++;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        chk("tick_en",     32'(sw_if.tick_en),     32'(m_tick_en));
        chk("clear",       32'(sw_if.clear),       32'(m_clear));
        chk("lap_capture", 32'(sw_if.lap_capture), 32'(m_lapcap));
        chk("show_lap",    32'(sw_if.show_lap),    32'(m_show));
        chk("running",     32'(sw_if.running),     32'(m_run));
        chk("state",       32'(sw_if.state),       32'(m_st));
        if (sw_if.tick_en) begin
            if (last_tick >= 0 && edge_n - last_tick != CLK_DIV) tick_gap_bad++;
            last_tick = edge_n;
            cnt_tick++;
        end
        if (sw_if.clear)       cnt_clear++;
        if (sw_if.lap_capture) cnt_lapcap++;
        if (sw_if.show_lap)    show_len++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input bit [3:0] m);
        sw_if.btn_start = m[0];
        sw_if.btn_lap   = m[1];
        sw_if.btn_stop  = m[2];
        sw_if.btn_clear = m[3];
    endtask

    task automatic press(input bit [3:0] m, input int hold, input int gap);
        set_btn(m);
        steps(hold);
        set_btn(4'b0000);
        steps(gap);
    endtask

    task automatic clr_counts();
        cnt_tick = 0; cnt_clear = 0; cnt_lapcap = 0; show_len = 0;
        last_tick = -1; tick_gap_bad = 0;
    endtask

    initial begin
        set_btn(4'b0000);
        clr_counts();

        // reset then idle
        RST = 1'b1;
        steps(2);
        RST = 1'b0;
        chk("rst_state", 32'(sw_if.state), 32'd0);
        clr_counts();
        steps(50);
        chk("idle_ticks", 32'(cnt_tick + cnt_clear + cnt_lapcap + show_len), 32'd0);
        chk("idle_state", 32'(sw_if.state), 32'd0);
        $display("step: idle 50 cycles, state=%0d", sw_if.state);

        // start: press visible at cycle 7, RUN from edge 8
        set_btn(4'b0001);
        steps(8);
        chk("start_latency_pre", 32'(sw_if.state), 32'd0);
        step();
        chk("start_state", 32'(sw_if.state), 32'd1);
        chk("start_running", 32'(sw_if.running), 32'd1);
        steps(11);
        set_btn(4'b0000);
        clr_counts();
        steps(45);
        chk("tick_count", 32'(cnt_tick), 32'd4);
        chk("tick_period", 32'(tick_gap_bad), 32'd0);
        $display("step: start, %0d tick_en pulses in 45 cycles", cnt_tick);

        // bounce on start while running
        press(4'b0001, 2, 2);
        press(4'b0001, 2, 15);
        chk("bounce_state", 32'(sw_if.state), 32'd1);
        $display("step: bounce, state=%0d", sw_if.state);

        // single lap: hold for 3 timebase ticks
        clr_counts();
        press(4'b0010, 6, 50);
        chk("lap_cap_once", 32'(cnt_lapcap), 32'd1);
        chk("lap_show_len_ok", 32'(show_len >= 21 && show_len <= 30), 32'd1);
        chk("lap_show_off", 32'(sw_if.show_lap), 32'd0);
        $display("step: lap, show_lap high %0d cycles", show_len);

        // reload during hold
        clr_counts();
        press(4'b0010, 6, 10);
        press(4'b0010, 6, 50);
        chk("lap_cap_twice", 32'(cnt_lapcap), 32'd2);
        chk("lap_reload_len_ok", 32'(show_len >= 37 && show_len <= 46), 32'd1);
        $display("step: lap reload, show_lap high %0d cycles", show_len);

        // stop and clear together while a lap is showing
        press(4'b0010, 6, 4);
        clr_counts();
        set_btn(4'b1100);
        steps(10);
        chk("clr_pulse", 32'(cnt_clear), 32'd1);
        set_btn(4'b0000);
        cnt_tick = 0;
        steps(30);
        chk("clr_state", 32'(sw_if.state), 32'd0);
        chk("clr_show", 32'(sw_if.show_lap), 32'd0);
        chk("clr_no_tick", 32'(cnt_tick), 32'd0);
        chk("clr_pulse_total", 32'(cnt_clear), 32'd1);
        $display("step: stop+clear, state=%0d", sw_if.state);

        // RUN -> PAUSE -> lap -> RUN, then reset mid-hold
        press(4'b0001, 6, 10);
        chk("p_run", 32'(sw_if.state), 32'd1);
        press(4'b0100, 6, 10);
        chk("p_pause", 32'(sw_if.state), 32'd2);
        press(4'b0010, 6, 4);
        press(4'b0001, 6, 4);
        chk("p_resume", 32'(sw_if.state), 32'd1);
        chk("p_hold_active", 32'(sw_if.show_lap), 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_all_zero", 32'({sw_if.tick_en, sw_if.clear, sw_if.lap_capture,
                                 sw_if.show_lap, sw_if.running, sw_if.state}), 32'd0);
        $display("step: reset mid-hold, state=%0d show_lap=%0d", sw_if.state, sw_if.show_lap);
        steps(5);

        // randomized single-button transactions, including glitches and rare resets
        for (int t = 0; t < 150; t++) begin
            int b, hold, gap;
            b    = $urandom_range(0, 3);
            hold = $urandom_range(1, 10);
            gap  = $urandom_range(8, 20);
            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b1;
                step();
                RST = 1'b0;
            end
            press(4'(1 << b), hold, gap);
            $display("txn %0d: button %0d hold %0d gap %0d -> state=%0d show_lap=%0d",
                     t, b, hold, gap, sw_if.state, sw_if.show_lap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
